// File: rtl/morse_message_sequencer_if.sv
// Letter-source handshake: 5-bit letter code with valid/ready backpressure.
interface morse_message_sequencer_if;
  logic [4:0] LetterIn;
  logic       LetterValid;
  logic       LetterReady;

  modport master (output LetterIn, output LetterValid, input LetterReady);
  modport slave  (input LetterIn, input LetterValid, output LetterReady);
endinterface

// File: rtl/morse_message_sequencer.sv
// Morse message sequencer: letter FIFO, pattern ROM and unit-timed keying FSM.
// Optional build macro MORSE_FARNSWORTH_EN adds GapMul to stretch letter/word gaps.
module morse_message_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LGAP_UNITS = 3,
  parameter int unsigned WGAP_UNITS = 4
) (
  input  logic                            ClockIn,
  input  logic                            Resetn,
  input  logic                            TickIn,
`ifdef MORSE_FARNSWORTH_EN
  input  logic [1:0]                      GapMul,
`endif
  morse_message_sequencer_if.slave        lif,
  output logic                            DotDashOut,
  output logic                            Busy,
  output logic                            Done,
  output logic                            ErrPulse
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNTW  = AW + 1;
`ifdef MORSE_FARNSWORTH_EN
  localparam int unsigned GMUL  = 3;
`else
  localparam int unsigned GMUL  = 1;
`endif
  localparam int unsigned GMAX  = ((LGAP_UNITS > WGAP_UNITS) ? LGAP_UNITS : WGAP_UNITS) * GMUL;
  localparam int unsigned CMAX  = (GMAX > 15) ? GMAX : 15;
  localparam int unsigned CW    = $clog2(CMAX + 1);
  localparam int unsigned PW    = 14;
  localparam logic [4:0]  WSPACE = 5'd31;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SYMBOL, S_LGAP, S_WGAP} state_t;

  // Element list (MSB-first, 1 = dash) expanded into a left-aligned key pattern and its length.
  function automatic logic [PW+3:0] morse_rom(input logic [4:0] code);
    logic [2:0]    n;
    logic [3:0]    els;
    logic [PW-1:0] pat;
    logic [3:0]    len;
    case (code)
      5'd0:  begin n = 3'd2; els = 4'b0100; end
      5'd1:  begin n = 3'd4; els = 4'b1000; end
      5'd2:  begin n = 3'd4; els = 4'b1010; end
      5'd3:  begin n = 3'd3; els = 4'b1000; end
      5'd4:  begin n = 3'd1; els = 4'b0000; end
      5'd5:  begin n = 3'd4; els = 4'b0010; end
      5'd6:  begin n = 3'd3; els = 4'b1100; end
      5'd7:  begin n = 3'd4; els = 4'b0000; end
      5'd8:  begin n = 3'd2; els = 4'b0000; end
      5'd9:  begin n = 3'd4; els = 4'b0111; end
      5'd10: begin n = 3'd3; els = 4'b1010; end
      5'd11: begin n = 3'd4; els = 4'b0100; end
      5'd12: begin n = 3'd2; els = 4'b1100; end
      5'd13: begin n = 3'd2; els = 4'b1000; end
      5'd14: begin n = 3'd3; els = 4'b1110; end
      5'd15: begin n = 3'd4; els = 4'b0110; end
      5'd16: begin n = 3'd4; els = 4'b1101; end
      5'd17: begin n = 3'd3; els = 4'b0100; end
      5'd18: begin n = 3'd3; els = 4'b0000; end
      5'd19: begin n = 3'd1; els = 4'b1000; end
      5'd20: begin n = 3'd3; els = 4'b0010; end
      5'd21: begin n = 3'd4; els = 4'b0001; end
      5'd22: begin n = 3'd3; els = 4'b0110; end
      5'd23: begin n = 3'd4; els = 4'b1001; end
      5'd24: begin n = 3'd4; els = 4'b1011; end
      5'd25: begin n = 3'd4; els = 4'b1100; end
      default: begin n = 3'd0; els = 4'b0000; end
    endcase
    pat = '0;
    len = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (3'(i) < n) begin
        if (i != 0) begin
          pat = {pat[PW-2:0], 1'b0};
          len = len + 4'd1;
        end
        if (els[3]) begin
          pat = {pat[PW-4:0], 3'b111};
          len = len + 4'd3;
        end else begin
          pat = {pat[PW-2:0], 1'b1};
          len = len + 4'd1;
        end
        els = {els[2:0], 1'b0};
      end
    end
    pat = pat << (4'd14 - len);
    return {len, pat};
  endfunction

  logic [4:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CNTW-1:0] count, count_nxt;
  logic           full, empty, code_ok, push, pop;

  state_t         state, state_nxt;
  logic [4:0]     cur, cur_nxt;
  logic [PW-1:0]  shreg, shreg_nxt;
  logic [CW-1:0]  cnt, cnt_nxt, lgap_len, wgap_len;
  logic           key_nxt, done_nxt, last_unit;
  logic [PW+3:0]  rom_word;

  assign full    = (count == CNTW'(DEPTH));
  assign empty   = (count == '0);
  assign code_ok = (lif.LetterIn <= 5'd25) || (lif.LetterIn == WSPACE);
  assign push    = lif.LetterValid && !full && code_ok;
  assign lif.LetterReady = !full;
  assign last_unit = TickIn && (cnt == CW'(1));
  assign rom_word  = morse_rom(cur);

`ifdef MORSE_FARNSWORTH_EN
  logic [1:0] mul_q, mul_now;
  assign mul_now  = (GapMul == 2'd0) ? 2'd1 : GapMul;
  assign wgap_len = CW'(WGAP_UNITS * mul_now);
  assign lgap_len = CW'(LGAP_UNITS * mul_q);

  // Gap multiplier captured once per item so it cannot change mid-letter.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn)               mul_q <= 2'd1;
    else if (state == S_LOAD)  mul_q <= mul_now;
  end
`else
  assign wgap_len = CW'(WGAP_UNITS);
  assign lgap_len = CW'(LGAP_UNITS);
`endif

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge ClockIn) begin
    if (push) mem[wr_ptr] <= lif.LetterIn;
  end

  // Next occupancy; push and pop in the same cycle cancel.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNTW'(1);
      2'b01:   count_nxt = count - CNTW'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // State register.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; an item is popped whenever the FSM heads into LOAD.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD:   state_nxt = (cur == WSPACE) ? S_WGAP : S_SYMBOL;
      S_SYMBOL: if (last_unit) state_nxt = S_LGAP;
      S_LGAP, S_WGAP: if (last_unit) begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values; keying only moves on tick edges.
  always_comb begin
    cur_nxt   = pop ? mem[rd_ptr] : cur;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    key_nxt   = DotDashOut;
    done_nxt  = 1'b0;
    case (state)
      S_LOAD: begin
        key_nxt = 1'b0;
        if (cur == WSPACE) begin
          cnt_nxt = wgap_len;
        end else begin
          shreg_nxt = rom_word[PW-1:0];
          cnt_nxt   = CW'(rom_word[PW+3:PW]);
        end
      end
      S_SYMBOL: if (TickIn) begin
        key_nxt   = shreg[PW-1];
        shreg_nxt = {shreg[PW-2:0], 1'b0};
        cnt_nxt   = (cnt == CW'(1)) ? lgap_len : cnt - CW'(1);
      end
      S_LGAP, S_WGAP: if (TickIn) begin
        key_nxt  = 1'b0;
        cnt_nxt  = cnt - CW'(1);
        done_nxt = (cnt == CW'(1)) && empty;
      end
      default: key_nxt = 1'b0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      cur        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      DotDashOut <= 1'b0;
      Done       <= 1'b0;
      ErrPulse   <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      cur        <= cur_nxt;
      shreg      <= shreg_nxt;
      cnt        <= cnt_nxt;
      DotDashOut <= key_nxt;
      Done       <= done_nxt;
      ErrPulse   <= lif.LetterValid && !code_ok;
      Busy       <= (state_nxt != S_IDLE) || (count_nxt != '0);
    end
  end

endmodule
